// File: rtl/exe_stage_if.sv
// Execute-stage bus: ID/EX outputs in, branch resolution, status and EX/MEM outputs back.
interface exe_stage_if;
    logic        freeze;
    logic        WB_EN_IN;
    logic        MEM_R_EN_IN;
    logic        MEM_W_EN_IN;
    logic        B_IN;
    logic        S_IN;
    logic [3:0]  EXE_CMD_IN;
    logic [31:0] PC_IN;
    logic [31:0] Val_Rn_IN;
    logic [31:0] Val_Rm_IN;
    logic        imm_IN;
    logic [11:0] Shift_operand_IN;
    logic [23:0] Signed_imm_24_IN;
    logic [3:0]  Dest_IN;

    logic        Branch_Taken;
    logic [31:0] Branch_Addr;
    logic [3:0]  SR;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm;
    logic [3:0]  Dest;

    // Upstream pipeline / environment side
    modport master (
        output freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN,
               PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN,
               Signed_imm_24_IN, Dest_IN,
        input  Branch_Taken, Branch_Addr, SR, WB_EN, MEM_R_EN, MEM_W_EN,
               ALU_Res, Val_Rm, Dest
    );

    // Execute stage side
    modport slave (
        input  freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN,
               PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN,
               Signed_imm_24_IN, Dest_IN,
        output Branch_Taken, Branch_Addr, SR, WB_EN, MEM_R_EN, MEM_W_EN,
               ALU_Res, Val_Rm, Dest
    );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU, NZCV register, branch target and EX/MEM register.
module exe_stage (
    input logic        clk,
    input logic        rst,
    exe_stage_if.slave bus
);
    localparam int unsigned DW = 32;

    function automatic logic [DW-1:0] ror32(input logic [DW-1:0] x, input logic [4:0] s);
        return DW'({x, x} >> s);
    endfunction

    logic [DW-1:0] val2;
    logic [DW-1:0] rn;
    logic [DW-1:0] alu_res;
    logic [DW:0]   sum33;
    logic          cin;
    logic          c_new;
    logic          v_new;
    logic [4:0]    shamt;

    logic          wb_en_q,    wb_en_d;
    logic          mem_r_en_q, mem_r_en_d;
    logic          mem_w_en_q, mem_w_en_d;
    logic [DW-1:0] alu_res_q,  alu_res_d;
    logic [DW-1:0] val_rm_q,   val_rm_d;
    logic [3:0]    dest_q,     dest_d;
    logic [3:0]    sr_q,       sr_d;

    assign rn    = bus.Val_Rn_IN;
    assign cin   = sr_q[1];
    assign shamt = bus.Shift_operand_IN[11:7];

    // Second operand: memory offset, rotated immediate or shifted register
    always_comb begin
        val2 = '0;
        if (bus.MEM_R_EN_IN | bus.MEM_W_EN_IN) begin
            val2 = {20'b0, bus.Shift_operand_IN};
        end else if (bus.imm_IN) begin
            val2 = ror32({24'b0, bus.Shift_operand_IN[7:0]}, {bus.Shift_operand_IN[11:8], 1'b0});
        end else begin
            case (bus.Shift_operand_IN[6:5])
                2'b00:   val2 = bus.Val_Rm_IN << shamt;
                2'b01:   val2 = bus.Val_Rm_IN >> shamt;
                2'b10:   val2 = DW'($signed(bus.Val_Rm_IN) >>> shamt);
                default: val2 = ror32(bus.Val_Rm_IN, shamt);
            endcase
        end
    end

    // ALU; subtracts use Rn + ~Val2 + 1 so bit 32 is the ARM-style not-borrow carry
    always_comb begin
        alu_res = '0;
        sum33   = '0;
        c_new   = sr_q[1];
        v_new   = sr_q[0];
        case (bus.EXE_CMD_IN)
            4'b0001: alu_res = val2;
            4'b1001: alu_res = ~val2;
            4'b0010, 4'b0011: begin
                sum33   = {1'b0, rn} + {1'b0, val2}
                        + ((bus.EXE_CMD_IN == 4'b0011) ? 33'(cin) : 33'd0);
                alu_res = sum33[DW-1:0];
                c_new   = sum33[DW];
                v_new   = (rn[31] == val2[31]) && (alu_res[31] != rn[31]);
            end
            4'b0100, 4'b0101: begin
                sum33   = {1'b0, rn} + {1'b0, ~val2}
                        + ((bus.EXE_CMD_IN == 4'b0101) ? 33'(cin) : 33'd1);
                alu_res = sum33[DW-1:0];
                c_new   = sum33[DW];
                v_new   = (rn[31] != val2[31]) && (alu_res[31] != rn[31]);
            end
            4'b0110: alu_res = rn & val2;
            4'b0111: alu_res = rn | val2;
            4'b1000: alu_res = rn ^ val2;
            default: alu_res = '0;
        endcase
    end

    // Next-state for status and EX/MEM registers; freeze holds everything
    always_comb begin
        sr_d       = sr_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        alu_res_d  = alu_res_q;
        val_rm_d   = val_rm_q;
        dest_d     = dest_q;
        if (!bus.freeze) begin
            if (bus.S_IN) begin
                sr_d = {alu_res[31], (alu_res == '0), c_new, v_new};
            end
            wb_en_d    = bus.WB_EN_IN;
            mem_r_en_d = bus.MEM_R_EN_IN;
            mem_w_en_d = bus.MEM_W_EN_IN;
            alu_res_d  = alu_res;
            val_rm_d   = bus.Val_Rm_IN;
            dest_d     = bus.Dest_IN;
        end
    end

    // State registers with synchronous reset taking priority over freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q       <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
        end else begin
            sr_q       <= sr_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            alu_res_q  <= alu_res_d;
            val_rm_q   <= val_rm_d;
            dest_q     <= dest_d;
        end
    end

    assign bus.Branch_Taken = bus.B_IN;
    assign bus.Branch_Addr  = bus.PC_IN + {{6{bus.Signed_imm_24_IN[23]}}, bus.Signed_imm_24_IN, 2'b00};
    assign bus.SR           = sr_q;
    assign bus.WB_EN        = wb_en_q;
    assign bus.MEM_R_EN     = mem_r_en_q;
    assign bus.MEM_W_EN     = mem_w_en_q;
    assign bus.ALU_Res      = alu_res_q;
    assign bus.Val_Rm       = val_rm_q;
    assign bus.Dest         = dest_q;
endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage with hand-computed expectations.
module tb_exe_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    exe_stage_if bus();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.freeze           = 1'b0;
        bus.WB_EN_IN         = 1'b0;
        bus.MEM_R_EN_IN      = 1'b0;
        bus.MEM_W_EN_IN      = 1'b0;
        bus.B_IN             = 1'b0;
        bus.S_IN             = 1'b0;
        bus.EXE_CMD_IN       = 4'h0;
        bus.PC_IN            = 32'h0;
        bus.Val_Rn_IN        = 32'h0;
        bus.Val_Rm_IN        = 32'h0;
        bus.imm_IN           = 1'b0;
        bus.Shift_operand_IN = 12'h0;
        bus.Signed_imm_24_IN = 24'h0;
        bus.Dest_IN          = 4'h0;
    endtask

    task automatic alu_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                          input logic imm, input logic [11:0] sh, input logic s);
        clear_in();
        bus.EXE_CMD_IN       = cmd;
        bus.Val_Rn_IN        = rn;
        bus.Val_Rm_IN        = rm;
        bus.imm_IN           = imm;
        bus.Shift_operand_IN = sh;
        bus.S_IN             = s;
        bus.WB_EN_IN         = 1'b1;
    endtask

    task automatic run_alu(input string tag, input logic [3:0] cmd, input logic [31:0] rn,
                           input logic [31:0] rm, input logic imm, input logic [11:0] sh,
                           input logic s, input logic [31:0] exp_res, input logic [3:0] exp_sr);
        alu_op(cmd, rn, rm, imm, sh, s);
        tick();
        check({tag, "_res"}, bus.ALU_Res, exp_res);
        check({tag, "_sr"}, 32'(bus.SR), 32'(exp_sr));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_in();
        rst = 1'b1;
        tick();
        tick();
        check("rst_alu", bus.ALU_Res, 32'h0);
        check("rst_sr", 32'(bus.SR), 32'h0);
        check("rst_ctl", {29'b0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 32'h0);
        check("rst_dest", 32'(bus.Dest), 32'h0);
        rst = 1'b0;

        // Arithmetic and flags
        run_alu("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0, 12'h000, 1'b1, 32'h8000_0000, 4'b1001);
        check("add_wb", 32'(bus.WB_EN), 32'h1);
        run_alu("sub_zero", 4'b0100, 32'h5, 32'h0, 1'b1, 12'h005, 1'b1, 32'h0, 4'b0110);
        run_alu("adc_cin", 4'b0011, 32'h1, 32'h0, 1'b1, 12'h001, 1'b0, 32'h3, 4'b0110);
        run_alu("sub_borrow", 4'b0100, 32'h0, 32'h0, 1'b1, 12'h001, 1'b1, 32'hFFFF_FFFF, 4'b1000);
        run_alu("sbc", 4'b0101, 32'h5, 32'h0, 1'b1, 12'h002, 1'b1, 32'h2, 4'b0010);
        run_alu("undef", 4'b1111, 32'h1234, 32'h5678, 1'b0, 12'h000, 1'b1, 32'h0, 4'b0110);

        // Operand generation
        run_alu("mov_rot", 4'b0001, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0, 32'hFF00_0000, 4'b0110);
        run_alu("mov_asr", 4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h240, 1'b0, 32'hF800_0000, 4'b0110);
        run_alu("mov_ror", 4'b0001, 32'h0, 32'h0000_000F, 1'b0, 12'h260, 1'b0, 32'hF000_0000, 4'b0110);
        run_alu("mov_lsr", 4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h220, 1'b0, 32'h0800_0000, 4'b0110);
        run_alu("mov_lsl31", 4'b0001, 32'h0, 32'h1, 1'b0, 12'hF80, 1'b0, 32'h8000_0000, 4'b0110);
        run_alu("asr_sh0", 4'b0001, 32'h0, 32'h8000_0001, 1'b0, 12'h040, 1'b0, 32'h8000_0001, 4'b0110);

        // Logical ops keep C/V
        run_alu("and", 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 12'h000, 1'b1, 32'hF000_F000, 4'b1010);
        run_alu("orr", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 12'h000, 1'b0, 32'hFFF0_FFF0, 4'b1010);
        run_alu("eor", 4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 12'h000, 1'b0, 32'h0FF0_0FF0, 4'b1010);
        run_alu("mvn", 4'b1001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b0, 32'hFFFF_FFFF, 4'b1010);

        // Load: offset wins over immediate form
        alu_op(4'b0010, 32'h400, 32'h0, 1'b1, 12'h0FF, 1'b0);
        bus.MEM_R_EN_IN = 1'b1;
        bus.Dest_IN     = 4'd5;
        tick();
        check("ldr_addr", bus.ALU_Res, 32'h4FF);
        check("ldr_ren", 32'(bus.MEM_R_EN), 32'h1);
        check("ldr_dest", 32'(bus.Dest), 32'h5);
        check("ldr_sr", 32'(bus.SR), 32'hA);

        // Store
        alu_op(4'b0010, 32'h100, 32'hDEAD_BEEF, 1'b0, 12'h010, 1'b0);
        bus.MEM_W_EN_IN = 1'b1;
        bus.WB_EN_IN    = 1'b0;
        tick();
        check("str_addr", bus.ALU_Res, 32'h110);
        check("str_wen", {30'b0, bus.MEM_W_EN, bus.WB_EN}, 32'h2);
        check("str_data", bus.Val_Rm, 32'hDEAD_BEEF);

        // Branch resolves combinationally
        clear_in();
        bus.B_IN             = 1'b1;
        bus.PC_IN            = 32'h100;
        bus.Signed_imm_24_IN = 24'hFFFFFE;
        #1;
        check("br_taken", 32'(bus.Branch_Taken), 32'h1);
        check("br_back", bus.Branch_Addr, 32'h0000_00F8);
        bus.PC_IN            = 32'h1000;
        bus.Signed_imm_24_IN = 24'h000004;
        #1;
        check("br_fwd", bus.Branch_Addr, 32'h0000_1010);
        tick();
        check("br_sr", 32'(bus.SR), 32'hA);

        // Bubble
        clear_in();
        tick();
        check("bub_ctl", {29'b0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 32'h0);
        check("bub_res", bus.ALU_Res, 32'h0);
        check("bub_sr", 32'(bus.SR), 32'hA);

        // Freeze holds registers and SR while branch outputs still track
        alu_op(4'b0010, 32'h10, 32'h20, 1'b0, 12'h000, 1'b1);
        bus.Dest_IN = 4'd7;
        tick();
        check("pre_frz_res", bus.ALU_Res, 32'h30);
        check("pre_frz_sr", 32'(bus.SR), 32'h0);
        for (int i = 0; i < 3; i++) begin
            alu_op(4'b0100, 32'(i), 32'h0, 1'b1, 12'h001 + 12'(i), 1'b1);
            bus.Dest_IN          = 4'd9;
            bus.freeze           = 1'b1;
            bus.B_IN             = 1'b1;
            bus.PC_IN            = 32'h200;
            bus.Signed_imm_24_IN = 24'h000001;
            tick();
            check("frz_res", bus.ALU_Res, 32'h30);
            check("frz_sr", 32'(bus.SR), 32'h0);
            check("frz_dest", 32'(bus.Dest), 32'h7);
            check("frz_br", bus.Branch_Addr, 32'h204);
        end
        alu_op(4'b0100, 32'h0, 32'h0, 1'b1, 12'h001, 1'b1);
        bus.Dest_IN = 4'd9;
        tick();
        check("unfrz_res", bus.ALU_Res, 32'hFFFF_FFFF);
        check("unfrz_sr", 32'(bus.SR), 32'h8);
        check("unfrz_dest", 32'(bus.Dest), 32'h9);

        // Reset during freeze clears everything
        bus.freeze = 1'b1;
        rst        = 1'b1;
        tick();
        rst = 1'b0;
        check("frz_rst_res", bus.ALU_Res, 32'h0);
        check("frz_rst_sr", 32'(bus.SR), 32'h0);
        check("frz_rst_misc", {bus.Val_Rm[27:0], bus.Dest}, 32'h0);
        check("frz_rst_ctl", {29'b0, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
